// File: rtl/microcode_store_if.sv
// Decode/load bus between the control unit and the microcode store.
interface microcode_store_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] decode_addr;
  logic [DATA_WIDTH-1:0] decode_data;
  logic                  load_start;
  logic                  load_end;
  logic [7:0]            load_byte;
  logic                  load_valid;
  logic                  load_ready;
  logic                  halt;
  logic                  load_error;
  logic [15:0]           load_words;

  modport master (
    output decode_addr, load_start, load_end, load_byte, load_valid,
    input  decode_data, load_ready, halt, load_error, load_words
  );

  modport slave (
    input  decode_addr, load_start, load_end, load_byte, load_valid,
    output decode_data, load_ready, halt, load_error, load_words
  );
endinterface

// File: rtl/microcode_store.sv
// Microcode store: runtime-loaded from a little-endian byte stream,
// read combinationally by the control unit once a clean load has finished.
module microcode_store #(
  parameter int                    ADDR_WIDTH = 15,
  parameter int                    DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 24'hFFFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  microcode_store_if.slave   bus
);

  typedef enum logic [1:0] {EMPTY, LOAD, READY, ERROR} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_done;
  logic [1:0]            byte_idx;
  logic [1:0]            idx_after;
  logic [15:0]           asm_lo;
  logic [15:0]           words;
  logic                  load_error;
  logic                  load_ready;
  logic                  accept;
  logic                  word_done;
  logic                  last_write;

  assign load_ready = (state == LOAD) && !addr_done;

  // Byte acceptance and next state; a byte is taken before i_loadEnd is judged.
  always_comb begin
    accept     = bus.load_valid && load_ready && !bus.load_start;
    word_done  = accept && (byte_idx == 2'd2);
    last_write = word_done && (addr == '1);
    idx_after  = byte_idx;
    if (accept) begin
      idx_after = word_done ? 2'd0 : byte_idx + 2'd1;
    end
    state_nxt = state;
    if (bus.load_start) begin
      state_nxt = LOAD;
    end else if (state == LOAD) begin
      if (last_write) begin
        state_nxt = READY;
      end else if (bus.load_end) begin
        state_nxt = (idx_after == 2'd0) ? READY : ERROR;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Load datapath: byte assembly, write address, word count and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      addr_done  <= 1'b0;
      byte_idx   <= '0;
      asm_lo     <= '0;
      words      <= '0;
      load_error <= 1'b0;
    end else if (bus.load_start) begin
      addr       <= '0;
      addr_done  <= 1'b0;
      byte_idx   <= '0;
      words      <= '0;
      load_error <= 1'b0;
    end else begin
      if (accept) begin
        case (byte_idx)
          2'd0:    asm_lo[7:0]  <= bus.load_byte;
          2'd1:    asm_lo[15:8] <= bus.load_byte;
          default: begin
            addr  <= addr + ADDR_WIDTH'(1);
            words <= words + 16'd1;
            if (addr == '1) begin
              addr_done <= 1'b1;
            end
          end
        endcase
      end
      // Leaving LOAD discards any partial word.
      byte_idx <= (state_nxt == LOAD) ? idx_after : 2'd0;
      if (state == LOAD && state_nxt == ERROR) begin
        load_error <= 1'b1;
      end
    end
  end

  // Word write on the third byte; memory survives reset.
  always_ff @(posedge clk) begin
    if (word_done) begin
      mem[addr] <= {bus.load_byte, asm_lo};
    end
  end

  assign bus.decode_data = (state == READY) ? mem[bus.decode_addr] : IDLE_WORD;
  assign bus.halt        = (state != READY);
  assign bus.load_ready  = load_ready;
  assign bus.load_error  = load_error;
  assign bus.load_words  = words;

endmodule

// File: tb/tb_microcode_store.sv
// Scoreboard bench for microcode_store with a byte-stream reference model.
module tb_microcode_store;
  localparam int AW    = 8;
  localparam int DW    = 24;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  microcode_store_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  microcode_store #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .IDLE_WORD (24'hFFFFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        halt;
    logic        rdy;
    logic        err;
    logic [15:0] words;
    logic        cd;
    logic [15:0] id;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  logic probe_en = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   pid = 0;

  // Reference model: load progress as a list of pending bytes and a word count.
  logic [23:0] m_mem [DEPTH];
  bit          m_written [DEPTH];
  logic [7:0]  m_pend[$];
  bit          m_loading = 0;
  bit          m_ready = 0;
  bit          m_error = 0;
  int          m_words = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s probe%0d: got %0h want %0h", nm, id, act, exp);
  endtask

  task automatic model_reset();
    m_loading = 0; m_ready = 0; m_error = 0; m_words = 0;
    m_pend.delete();
  endtask

  task automatic model_step(input bit s, input bit en, input bit v, input logic [7:0] b);
    if (s) begin
      m_loading = 1; m_ready = 0; m_error = 0; m_words = 0;
      m_pend.delete();
    end else if (m_loading) begin
      if (v) begin
        m_pend.push_back(b);
        if (m_pend.size() == 3) begin
          m_mem[m_words]     = {m_pend[2], m_pend[1], m_pend[0]};
          m_written[m_words] = 1;
          m_words++;
          m_pend.delete();
          if (m_words == DEPTH) begin
            m_loading = 0;
            m_ready   = 1;
          end
        end
      end
      if (m_loading && en) begin
        if (m_pend.size() == 0) m_ready = 1;
        else m_error = 1;
        m_loading = 0;
        m_pend.delete();
      end
    end
  endtask

  task automatic step(input bit s, input bit en, input bit v, input logic [7:0] b);
    bus.load_start = s; bus.load_end = en; bus.load_valid = v; bus.load_byte = b;
    @(posedge clk); #1;
    model_step(s, en, v, b);
    bus.load_start = 0; bus.load_end = 0; bus.load_valid = 0; bus.load_byte = 8'h00;
  endtask

  task automatic probe(input logic [AW-1:0] a);
    exp_t e;
    e.halt  = !m_ready;
    e.rdy   = m_loading;
    e.err   = m_error;
    e.words = 16'(m_words);
    e.cd    = !m_ready || m_written[a];
    e.data  = m_ready ? m_mem[a] : 24'hFFFFFF;
    e.id    = 16'(pid);
    pid++;
    sb.push_back(e);
    bus.decode_addr = a;
    probe_en = 1'b1;
    @(posedge clk); #1;
    probe_en = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(DEPTH - 1));
    for (int t = 0; t < 64; t++) begin
      if (m_written[a]) break;
      a = AW'($urandom_range(DEPTH - 1));
    end
    return a;
  endfunction

  // Monitor: every probed cycle is matched against the oldest expectation.
  always @(negedge clk) begin
    if (probe_en) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL sb_underflow: got probe with no expectation, want one queued");
      end else begin
        me = sb.pop_front();
        chk("halt",       int'(me.id), 32'(bus.halt),       32'(me.halt));
        chk("load_ready", int'(me.id), 32'(bus.load_ready), 32'(me.rdy));
        chk("load_error", int'(me.id), 32'(bus.load_error), 32'(me.err));
        chk("load_words", int'(me.id), 32'(bus.load_words), 32'(me.words));
        if (me.cd) chk("decode_data", int'(me.id), 32'(bus.decode_data), 32'(me.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [6];
    int n;
    t1[0] = 8'h01; t1[1] = 8'h02; t1[2] = 8'h03;
    t1[3] = 8'hAA; t1[4] = 8'hBB; t1[5] = 8'hCC;
    bus.decode_addr = '0; bus.load_start = 0; bus.load_end = 0;
    bus.load_valid = 0; bus.load_byte = 8'h00;

    // Reset state.
    @(posedge clk); #1;
    probe(8'd0);
    rst_n = 1'b1;
    probe(8'd3);

    // 1: two clean words.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 0, 1, t1[i]);
    step(0, 1, 0, 8'h00);
    probe(8'd0);
    probe(8'd1);

    // 4: valid held while READY leaves everything alone.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'($urandom));
    probe(8'd0);

    // 2: partial word then end.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'($urandom));
    probe(8'd5);
    step(0, 1, 0, 8'h00);
    probe(8'd0);
    probe(8'($urandom));

    // Third byte together with end writes the word and finishes cleanly.
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h11);
    step(0, 0, 1, 8'h22);
    step(0, 1, 1, 8'h33);
    probe(8'd0);

    // 3: full load with random gaps, then an extra byte.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      while ($urandom_range(3) == 0) step(0, 0, 0, 8'h00);
      if (i == 3 * DEPTH - 1) probe(8'd0);
      step(0, 0, 1, 8'($urandom));
    end
    probe(8'(DEPTH - 1));
    step(0, 0, 1, 8'h5A);
    probe(8'(DEPTH - 1));
    probe(pick_addr());

    // 5: asynchronous reset mid-load, then a one-word reload.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'($urandom));
    #2;
    rst_n = 1'b0;
    model_reset();
    probe(8'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'($urandom));
    probe(8'd1);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'($urandom));
    step(0, 1, 0, 8'h00);
    probe(8'd0);
    probe(8'd1);

    // 6: start and valid together in READY drops the byte.
    step(1, 0, 1, 8'hEE);
    probe(8'd0);
    step(0, 0, 1, 8'h44);
    step(0, 0, 1, 8'h55);
    step(0, 0, 1, 8'h66);
    step(0, 1, 0, 8'h00);
    probe(8'd0);

    // Random short loads, ends aligned or not.
    for (int k = 0; k < 8; k++) begin
      step(1, 0, $urandom_range(1), 8'($urandom));
      n = $urandom_range(10);
      for (int i = 0; i < n; i++) step(0, 0, 1, 8'($urandom));
      step(0, 1, $urandom_range(1), 8'($urandom));
      probe(pick_addr());
      probe(8'd0);
    end

    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("sb_drain", -1, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
